// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register-bank write scheduler.
// Holds the scheduler state encoding and the address/index width helper.
package reg_bank_pkg;

  localparam int MAX_N_REQ = 8;
  localparam int MAX_DEPTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Index/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_bank_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr,
// wrapping, wins. Produces a one-hot grant plus the winning index.
module rr_arbiter
  import reg_bank_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int              cand;
  logic [ID_W-1:0] cidx;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    cidx = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = ID_W'(cand);
      if (!any && req[cidx]) begin
        any       = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/reg_bank_scheduler.sv
// Round-robin write scheduler for an internal register bank: one registered
// grant per cycle, committed to the bank on the following edge.
module reg_bank_scheduler
  import reg_bank_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = clog2_min1(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*ADDR_W-1:0]       req_addr,
  input  logic [N_REQ*WIDTH-1:0]        req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DEPTH*WIDTH-1:0]        bank_q,
  output logic                          busy,
  output logic [clog2_min1(N_REQ)-1:0]  grant_id,
  output logic                          addr_err
);

  localparam int ID_W = clog2_min1(N_REQ);

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, gnt_id, arb_idx;
  logic [ADDR_W-1:0] gnt_addr, sel_addr;
  logic [WIDTH-1:0]  gnt_data, sel_data;
  logic [N_REQ-1:0]  masked, arb_gnt;
  logic              arb_any, wr_en, addr_oob;

  // The requester being written now still holds valid; keep it out of arbitration.
  assign masked = req_valid & ~req_ready;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req (masked),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign addr_oob = int'(gnt_addr) >= DEPTH;
  assign grant_id = gnt_id;

  always_comb begin
    state_nx  = IDLE;
    req_ready = '0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    if (arb_any) state_nx = WRITE;
    if (state == WRITE) begin
      busy              = 1'b1;
      req_ready[gnt_id] = 1'b1;
      wr_en             = !addr_oob;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_id   <= '0;
      addr_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (arb_any) begin
        gnt_id <= arb_idx;
        ptr    <= (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
      end
      if (state == WRITE && addr_oob) addr_err <= 1'b1;
    end
  end

  // Grant payload is pure data and needs no reset; state gates its use.
  always_ff @(posedge clk) begin
    if (arb_any) begin
      gnt_addr <= sel_addr;
      gnt_data <= sel_data;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              q <= '0;
      else if (wr_en && int'(gnt_addr) == k)   q <= gnt_data;
    end
    assign bank_q[k*WIDTH +: WIDTH] = q;
  end

endmodule
